time_of_day_counter: RTL and testbench
======================================

# time_of_day_counter

Two-digit-BCD hours/minutes/seconds counter that consumes the four square-wave tick outputs of the frequency divider (0.1 Hz, 1 Hz, 10 Hz and 100 Hz lanes on `q_in[3:0]`). It selects one lane, detects rising edges and advances an HH:MM:SS count on each one. Its BCD outputs feed the display driver. The faster lanes allow accelerated counting for bring-up and test.

## Interface
- `HR_WRAP`, 24: number of hour states; hours count `0..HR_WRAP-1`; legal range 2..24.
- `clk`  in  1  system clock, the same clock that drives the divider.
- `rst_n`  in  1  asynchronous, active-low reset.
- `q_in`  in  4  divider square waves: [0]=0.1 Hz, [1]=1 Hz, [2]=10 Hz, [3]=100 Hz; synchronous to `clk`.
- `sel`  in  2  lane select; index into `q_in`.
- `run`  in  1  level; 1 = count selected-lane edges, 0 = hold and allow setting.
- `clear`  in  1  synchronous clear to 00:00:00.
- `inc_min`  in  1  single-cycle set pulse: minutes +1.
- `inc_hr`  in  1  single-cycle set pulse: hours +1.
- `sec_bcd`  out  8  seconds, {tens, units} BCD.
- `min_bcd`  out  8  minutes, BCD.
- `hr_bcd`  out  8  hours, BCD.
- `tick_o`  out  1  one-cycle pulse on each counted edge.
- `day_o`  out  1  one-cycle pulse on wrap from last hour:59:59 to 00:00:00.

## Operation
- Reset (asynchronous, active-low): all count outputs 0x00; `tick_o`=0; `day_o`=0; both edge-detect register stages set to all ones.
  - Consequence: a lane already high when reset is released is not counted. A real 0→1 transition is required.
- Edge detection runs on all 4 lanes in parallel: `q_r <= q_in`, `q_rr <= q_r`, `edge[i] = q_r[i] & ~q_rr[i]`.
- Selected edge = `edge[sel]`.
  - Changing `sel` never fabricates an edge.
  - An edge on the new lane counts from the first cycle `sel` points at it.
- Priority per cycle: `clear` > counting (`run`=1) > setting (`run`=0).
- `clear`=1:
  - All counts become 00.
  - `tick_o`=0 and `day_o`=0.
  - Any edge, `inc_min` or `inc_hr` in the same cycle is dropped.
- `run`=1 with a selected edge:
  - Seconds +1; 59→00 carries into minutes.
  - Minutes 59→00 carries into hours.
  - Hours `HR_WRAP-1`→00 asserts `day_o`.
  - `tick_o`=1 in the same cycle the new count appears.
- `run`=1: `inc_min` and `inc_hr` are ignored.
- `run`=0:
  - Edges are ignored and `tick_o` stays 0.
  - `inc_min`: minutes +1, 59→00, no carry into hours; seconds unchanged.
  - `inc_hr`: hours +1, wrap to 00, no `day_o`.
  - Both pulses in the same cycle both apply.
- BCD units digit 9→0 increments the tens digit. The module never produces an illegal BCD digit.
- `HR_WRAP`=24: hours run 00..23. `HR_WRAP`=12: hours run 00..11.

## Timing
- A lane's input first goes high in cycle n after being low in cycle n-1.
  - With that lane selected during cycle n+1, new count values appear in cycle n+2.
  - `tick_o` (and `day_o` if wrapping) is high in cycle n+2 only.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Set pulses and `clear` sampled at edge k are visible at k+1.
- Minimum legal lane high and low time is 2 cycles, which the divider guarantees. Shorter pulses are undefined.
- An edge on a lane that is deselected before cycle n+1 is not counted.

## Structure
- Shared package `clock_pkg`:
  - BCD digit typedef and two-digit BCD typedef.
  - Lane-select encoding constants (`SEL_0P1HZ`=0 … `SEL_100HZ`=3).
  - Constant `BCD_59`=8'h59.
- Sub-module `bcd2_counter`:
  - Parameter: modulus.
  - Inputs: `clk`, `rst_n`, `clr`, `inc`.
  - Outputs: `val[7:0]`, `wrap` (combinational, asserted when `inc` and at max).
  - Instantiated three times: sec, min, hr.
- Top level holds the edge-detect registers, the lane mux, the priority logic and the `tick_o`/`day_o` registers.

## Test plan
- Reset with `q_in`=4'hF held, then release with `run`=1 and no transitions for 100 cycles → count stays 00:00:00 and `tick_o` never pulses.
- Use `sel`=3 and drive a 0→1 on `q_in[3]` in cycle n → `sec_bcd`=8'h01 and `tick_o`=1 in cycle n+2, `tick_o`=0 in n+3.
- Preload 23:59:59 via the set pulses plus 59 edges, then apply one edge → 00:00:00, and `day_o` and `tick_o` both pulse the same cycle. Repeat with `HR_WRAP`=12 from 11:59:59.
- `run`=0 at minutes 59 → `inc_min` gives minutes 00 with hours unchanged. Issue `inc_min` and `inc_hr` in the same cycle → both advance. Edges during `run`=0 → no change.
- Hold lane 2 high and lane 1 low, then switch `sel` 1→2 → no count. The next 0→1 on lane 2 counts once.
- `clear` asserted in the same cycle as a qualifying edge at 00:00:09 → next value is 00:00:00 and `tick_o` stays 0. Asserting `rst_n` low mid-count forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the time-of-day clock blocks.
// Provides BCD digit types, lane-select encodings and small BCD helpers.
package clock_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD2_W      = 2 * BCD_DIGIT_W;
  localparam int unsigned LANE_N      = 4;
  localparam int unsigned SEL_W       = 2;
  localparam int unsigned SEC_MOD     = 60;
  localparam int unsigned MIN_MOD     = 60;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t tens;
    bcd_digit_t units;
  } bcd2_t;

  // Lane-select encodings, matching the divider's q_in bit order
  localparam logic [SEL_W-1:0] SEL_0P1HZ = 2'd0;
  localparam logic [SEL_W-1:0] SEL_1HZ   = 2'd1;
  localparam logic [SEL_W-1:0] SEL_10HZ  = 2'd2;
  localparam logic [SEL_W-1:0] SEL_100HZ = 2'd3;

  localparam logic [BCD2_W-1:0] BCD_59 = 8'h59;

  // Binary (0..99) to two-digit BCD; used for elaboration-time constants
  function automatic bcd2_t bcd2_from_int(input int unsigned n);
    bcd2_t v;
    v.tens  = BCD_DIGIT_W'(n / 10);
    v.units = BCD_DIGIT_W'(n % 10);
    return v;
  endfunction

  // Two-digit BCD increment; units 9 rolls into the tens digit
  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.units == 4'd9) begin
      r.units = 4'd0;
      r.tens  = v.tens + 4'd1;
    end else begin
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// Two-digit BCD modulo counter used for the seconds, minutes and hours fields.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear to 00 (wins over inc)
//   inc        : advance by one this cycle
//   val        : registered BCD count {tens, units}
//   wrap       : combinational, high when inc is applied at MODULUS-1
module bcd2_counter
  import clock_pkg::*;
#(
  parameter int unsigned MODULUS = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [BCD2_W-1:0] val,
  output logic              wrap
);

  localparam bcd2_t MAX_VAL = bcd2_from_int(MODULUS - 1);

  bcd2_t r_val;
  bcd2_t w_next;
  logic  w_at_max;

  assign w_at_max = (r_val == MAX_VAL);
  assign wrap     = inc & w_at_max;

  // Next-count selection: clear, wrap to zero, or BCD increment
  always_comb begin
    w_next = r_val;
    if (clr) begin
      w_next = '0;
    end else if (inc) begin
      if (w_at_max) begin
        w_next = '0;
      end else begin
        w_next = bcd2_inc(r_val);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
    end else begin
      r_val <= w_next;
    end
  end

  assign val = r_val;

endmodule

// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD time-of-day counter driven by one selectable divider lane.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   q_in[3:0]        : divider square waves (0.1 / 1 / 10 / 100 Hz)
//   sel[1:0]         : lane select into q_in
//   run              : 1 = count lane edges, 0 = hold and accept set pulses
//   clear            : synchronous clear to 00:00:00, highest priority
//   inc_min, inc_hr  : set pulses, honoured only while run = 0
//   sec/min/hr_bcd   : registered BCD count
//   tick_o           : one-cycle pulse with each counted edge
//   day_o            : one-cycle pulse on wrap to 00:00:00 from the last hour
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int unsigned HR_WRAP = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_N-1:0] q_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic              run,
  input  logic              clear,
  input  logic              inc_min,
  input  logic              inc_hr,
  output logic [BCD2_W-1:0] sec_bcd,
  output logic [BCD2_W-1:0] min_bcd,
  output logic [BCD2_W-1:0] hr_bcd,
  output logic              tick_o,
  output logic              day_o
);

  logic [LANE_N-1:0] r_q_r;
  logic [LANE_N-1:0] r_q_rr;
  logic [LANE_N-1:0] w_edge;
  logic              w_sel_edge;
  logic              w_count;
  logic              w_set;
  logic              w_sec_inc;
  logic              w_min_inc;
  logic              w_hr_inc;
  logic              w_sec_wrap;
  logic              w_min_wrap;
  logic              w_hr_wrap;
  logic              r_tick;
  logic              r_day;

  // Edge history resets to all ones so a lane already high at release
  // must fall and rise again before it is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_r  <= '1;
      r_q_rr <= '1;
    end else begin
      r_q_r  <= q_in;
      r_q_rr <= r_q_r;
    end
  end

  // Edges are tracked on every lane, so switching sel never creates one
  assign w_edge     = r_q_r & ~r_q_rr;
  assign w_sel_edge = w_edge[sel];

  // clear > counting > setting
  assign w_count = ~clear & run & w_sel_edge;
  assign w_set   = ~clear & ~run;

  // Set pulses bypass the carry chain: inc_min never reaches hours
  assign w_sec_inc = w_count;
  assign w_min_inc = (w_count & w_sec_wrap) | (w_set & inc_min);
  assign w_hr_inc  = (w_count & w_min_wrap) | (w_set & inc_hr);

  bcd2_counter #(
    .MODULUS (SEC_MOD)
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_sec_inc),
    .val   (sec_bcd),
    .wrap  (w_sec_wrap)
  );

  bcd2_counter #(
    .MODULUS (MIN_MOD)
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_min_inc),
    .val   (min_bcd),
    .wrap  (w_min_wrap)
  );

  bcd2_counter #(
    .MODULUS (HR_WRAP)
  ) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (w_hr_inc),
    .val   (hr_bcd),
    .wrap  (w_hr_wrap)
  );

  // Hour wrap only signals a new day when it comes from the carry chain;
  // with run = 1 the set path is idle, so w_count qualifies it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= 1'b0;
      r_day  <= 1'b0;
    end else begin
      r_tick <= w_count;
      r_day  <= w_count & w_hr_wrap;
    end
  end

  assign tick_o = r_tick;
  assign day_o  = r_day;

endmodule

// File: tb/tb_time_of_day_counter.sv
// Self-checking bench: directed scenarios plus randomized lane/control
// stimulus, compared each cycle against an arithmetic clock model.
// Two instances run in parallel with HR_WRAP = 24 and HR_WRAP = 12.
module tb_time_of_day_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] q_in;
  logic [1:0] sel;
  logic       run;
  logic       clear;
  logic       inc_min;
  logic       inc_hr;

  logic [7:0] sec_a, min_a, hr_a;
  logic       tick_a, day_a;
  logic [7:0] sec_b, min_b, hr_b;
  logic       tick_b, day_b;

  always #5 clk = ~clk;

  time_of_day_counter #(.HR_WRAP(24)) u_dut24 (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_in    (q_in),
    .sel     (sel),
    .run     (run),
    .clear   (clear),
    .inc_min (inc_min),
    .inc_hr  (inc_hr),
    .sec_bcd (sec_a),
    .min_bcd (min_a),
    .hr_bcd  (hr_a),
    .tick_o  (tick_a),
    .day_o   (day_a)
  );

  time_of_day_counter #(.HR_WRAP(12)) u_dut12 (
    .clk     (clk),
    .rst_n   (rst_n),
    .q_in    (q_in),
    .sel     (sel),
    .run     (run),
    .clear   (clear),
    .inc_min (inc_min),
    .inc_hr  (inc_hr),
    .sec_bcd (sec_b),
    .min_bcd (min_b),
    .hr_bcd  (hr_b),
    .tick_o  (tick_b),
    .day_o   (day_b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: time kept as plain integers
  int m_sec, m_min, m_hr24, m_hr12;
  bit m_tick, m_day24, m_day12;
  // Lane levels observed at the most recent and the previous clock edge
  logic [3:0] seen_last, seen_prev;

  function automatic int bcd(input int n);
    return ((n / 10) * 16) + (n % 10);
  endfunction

  task automatic model_reset();
    m_sec = 0; m_min = 0; m_hr24 = 0; m_hr12 = 0;
    m_tick = 0; m_day24 = 0; m_day12 = 0;
    seen_last = 4'hF;
    seen_prev = 4'hF;
  endtask

  // Apply the clock's rules for the inputs present at this edge
  task automatic model_clock();
    bit rose;
    rose = seen_last[sel] && !seen_prev[sel];
    m_tick = 0; m_day24 = 0; m_day12 = 0;
    if (clear) begin
      m_sec = 0; m_min = 0; m_hr24 = 0; m_hr12 = 0;
    end else if (run) begin
      if (rose) begin
        m_tick = 1;
        m_sec++;
        if (m_sec == 60) begin
          m_sec = 0;
          m_min++;
          if (m_min == 60) begin
            m_min = 0;
            m_hr24++;
            m_hr12++;
            if (m_hr24 == 24) begin m_hr24 = 0; m_day24 = 1; end
            if (m_hr12 == 12) begin m_hr12 = 0; m_day12 = 1; end
          end
        end
      end
    end else begin
      if (inc_min) m_min = (m_min + 1) % 60;
      if (inc_hr) begin
        m_hr24 = (m_hr24 + 1) % 24;
        m_hr12 = (m_hr12 + 1) % 12;
      end
    end
    seen_prev = seen_last;
    seen_last = q_in;
  endtask

  task automatic compare_all();
    chk("sec24",  32'(sec_a),  32'(bcd(m_sec)));
    chk("min24",  32'(min_a),  32'(bcd(m_min)));
    chk("hr24",   32'(hr_a),   32'(bcd(m_hr24)));
    chk("tick24", 32'(tick_a), 32'(m_tick));
    chk("day24",  32'(day_a),  32'(m_day24));
    chk("sec12",  32'(sec_b),  32'(bcd(m_sec)));
    chk("min12",  32'(min_b),  32'(bcd(m_min)));
    chk("hr12",   32'(hr_b),   32'(bcd(m_hr12)));
    chk("tick12", 32'(tick_b), 32'(m_tick));
    chk("day12",  32'(day_b),  32'(m_day12));
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    compare_all();
  endtask

  // Low for two cycles then high for two; rise lands in the third cycle
  task automatic edge_on(input int lane);
    q_in[lane] = 1'b0;
    step();
    step();
    q_in[lane] = 1'b1;
    step();
    step();
  endtask

  int stab[4];

  initial begin
    rst_n = 1'b0; q_in = 4'hF; sel = 2'd3; run = 1'b1;
    clear = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Lanes held high through release: nothing may count
    repeat (100) step();

    // Single rise on the 100 Hz lane
    q_in[3] = 1'b0;
    step();
    step();
    q_in[3] = 1'b1;
    step();
    chk("edge_n1_sec", 32'(sec_a), 32'h00);
    step();
    chk("edge_n2_sec", 32'(sec_a), 32'h01);
    chk("edge_n2_tick", 32'(tick_a), 32'h1);
    step();
    chk("edge_n3_tick", 32'(tick_a), 32'h0);

    // Preload 23:59 / 11:59 with set pulses
    clear = 1'b1; step(); clear = 1'b0;
    run = 1'b0;
    inc_min = 1'b1; inc_hr = 1'b1;
    repeat (23) step();
    inc_min = 1'b0; inc_hr = 1'b0;
    chk("set_hr24", 32'(hr_a), 32'h23);
    chk("set_hr12", 32'(hr_b), 32'h11);
    chk("set_min_both", 32'(min_a), 32'h23);
    inc_min = 1'b1; repeat (36) step(); inc_min = 1'b0;
    chk("set_min59", 32'(min_a), 32'h59);
    inc_min = 1'b1; step(); inc_min = 1'b0;
    chk("min_wrap_nocarry_min", 32'(min_a), 32'h00);
    chk("min_wrap_nocarry_hr", 32'(hr_a), 32'h23);
    inc_min = 1'b1; repeat (59) step(); inc_min = 1'b0;
    inc_hr = 1'b1; step();
    chk("hr_set_wrap12", 32'(hr_b), 32'h00);
    chk("hr_set_wrap12_day", 32'(day_b), 32'h0);
    repeat (23) step();
    inc_hr = 1'b0;

    // Edges while held are ignored
    repeat (3) edge_on(3);
    chk("hold_sec", 32'(sec_a), 32'h00);

    run = 1'b1;
    repeat (59) edge_on(3);
    chk("pre_wrap_sec", 32'(sec_a), 32'h59);
    chk("pre_wrap_hr12", 32'(hr_b), 32'h11);
    edge_on(3);
    chk("day_wrap_hr24", 32'(hr_a), 32'h00);
    chk("day_wrap_min", 32'(min_a), 32'h00);
    chk("day_wrap_day24", 32'(day_a), 32'h1);
    chk("day_wrap_day12", 32'(day_b), 32'h1);
    chk("day_wrap_tick", 32'(tick_a), 32'h1);
    step();
    chk("day_pulse_end", 32'(day_a), 32'h0);

    // Switching onto an already-high lane must not count
    sel = 2'd1;
    q_in[1] = 1'b0; q_in[2] = 1'b0;
    step(); step();
    q_in[2] = 1'b1;
    repeat (3) step();
    sel = 2'd2;
    repeat (4) step();
    chk("sel_switch_nocount", 32'(sec_a), 32'h00);
    edge_on(2);
    chk("sel_switch_next_edge", 32'(sec_a), 32'h01);

    // clear coincident with a qualifying edge at 00:00:09
    clear = 1'b1; step(); clear = 1'b0;
    sel = 2'd3;
    repeat (9) edge_on(3);
    chk("pre_clear_sec", 32'(sec_a), 32'h09);
    q_in[3] = 1'b0; step(); step();
    q_in[3] = 1'b1; step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_edge_sec", 32'(sec_a), 32'h00);
    chk("clear_edge_tick", 32'(tick_a), 32'h0);

    // Asynchronous reset mid-count
    repeat (5) edge_on(3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sec", 32'(sec_a), 32'h00);
    chk("async_rst_min", 32'(min_b), 32'h00);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    step();

    // Randomized lanes, select, mode and set pulses
    for (int i = 0; i < 4; i++) stab[i] = 2;
    repeat (3000) begin
      for (int i = 0; i < 4; i++) begin
        if (stab[i] >= 2 && $urandom_range(0, 2) == 0) begin
          q_in[i] = ~q_in[i];
          stab[i] = 1;
        end else begin
          stab[i] = stab[i] + 1;
        end
      end
      if ($urandom_range(0, 15) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) run = ~run;
      clear   = ($urandom_range(0, 499) == 0);
      inc_min = ($urandom_range(0, 3) == 0);
      inc_hr  = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
